// File: rtl/rv32i_reg_file_acc.sv
// rv32i_reg_file_acc: RV32I/RV32E register file with a host mailbox.
// Purpose: holds the architectural GPRs and maps host-loaded argument
// registers and a read-only start flag into the register space. A
// three-state handshake (IDLE -> RUN -> DONE) lets the host launch a job.
// The core polls the start flag, and the core's write to the result
// register hands the value back to the host.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   rs1_addr/rs1_data   read port 1 (combinational)
//   rs2_addr/rs2_data   read port 2 (combinational)
//   rd_we/rd_addr/rd_data  write port
//   host_start          single-cycle job launch request
//   host_args           packed argument slices, arg i at [i*XLEN +: XLEN]
//   host_busy           high while a job is in RUN or DONE
//   result              captured job result
//   result_valid        high in DONE
//   result_ack          host consumes the result
module rv32i_reg_file_acc #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned NREGS      = 32,
    parameter int unsigned NUM_ARGS   = 2,
    parameter int unsigned ARG_BASE   = 28,
    parameter int unsigned START_REG  = 31,
    parameter int unsigned RESULT_REG = 10,
    parameter bit          BYPASS     = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [4:0]               rs1_addr,
    output logic [XLEN-1:0]          rs1_data,
    input  logic [4:0]               rs2_addr,
    output logic [XLEN-1:0]          rs2_data,
    input  logic                     rd_we,
    input  logic [4:0]               rd_addr,
    input  logic [XLEN-1:0]          rd_data,
    input  logic                     host_start,
    input  logic [NUM_ARGS*XLEN-1:0] host_args,
    output logic                     host_busy,
    output logic [XLEN-1:0]          result,
    output logic                     result_valid,
    input  logic                     result_ack
);

    localparam int unsigned GPR_IW = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam int unsigned ARG_IW = (NUM_ARGS > 1) ? $clog2(NUM_ARGS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [XLEN-1:0] gpr     [NREGS];
    logic [XLEN-1:0] arg_reg [NUM_ARGS];
    logic            wr_en;
    logic            result_wr;

    // Address lies in the host argument window.
    function automatic logic is_arg(input logic [4:0] a);
        return (32'(a) >= ARG_BASE) && (32'(a) < (ARG_BASE + NUM_ARGS));
    endfunction

    // Address names a GPR the core is allowed to write.
    function automatic logic is_writable(input logic [4:0] a);
        return (a != 5'd0) && (32'(a) < NREGS) && !is_arg(a) &&
               (32'(a) != START_REG);
    endfunction

    // Read mux in decreasing priority: x0, out-of-range, args, start flag,
    // same-cycle forwarding, stored GPR.
    function automatic logic [XLEN-1:0] read_port(input logic [4:0] a);
        logic [XLEN-1:0] v;
        v = '0;
        if (a == 5'd0) begin
            v = '0;
        end else if (32'(a) >= NREGS) begin
            v = '0;
        end else if (is_arg(a)) begin
            v = arg_reg[ARG_IW'(32'(a) - ARG_BASE)];
        end else if (32'(a) == START_REG) begin
            v = {{(XLEN-1){1'b0}}, (state == RUN)};
        end else if (BYPASS && rd_we && (rd_addr == a) && is_writable(a)) begin
            v = rd_data;
        end else begin
            v = gpr[GPR_IW'(a)];
        end
        return v;
    endfunction

    always_comb begin
        rs1_data = read_port(rs1_addr);
        rs2_data = read_port(rs2_addr);
    end

    assign wr_en     = rd_we && is_writable(rd_addr);
    assign result_wr = wr_en && (32'(rd_addr) == RESULT_REG);

    // GPR storage; writes to x0, args, start flag or out-of-range are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                gpr[i] <= '0;
            end
        end else if (wr_en) begin
            gpr[GPR_IW'(rd_addr)] <= rd_data;
        end
    end

    // Host handshake FSM with registered status outputs and argument capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            host_busy    <= 1'b0;
            result_valid <= 1'b0;
            result       <= '0;
            for (int i = 0; i < int'(NUM_ARGS); i++) begin
                arg_reg[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (host_start) begin
                        for (int i = 0; i < int'(NUM_ARGS); i++) begin
                            arg_reg[i] <= host_args[i*XLEN +: XLEN];
                        end
                        state     <= RUN;
                        host_busy <= 1'b1;
                    end
                end
                RUN: begin
                    if (result_wr) begin
                        result       <= rd_data;
                        result_valid <= 1'b1;
                        state        <= DONE;
                    end
                end
                DONE: begin
                    // host_start is ignored here, even alongside the ack.
                    if (result_ack) begin
                        result_valid <= 1'b0;
                        host_busy    <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: begin
                    state        <= IDLE;
                    host_busy    <= 1'b0;
                    result_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv32i_reg_file_acc.sv
// Bench for rv32i_reg_file_acc: default instance, a BYPASS=0 instance and an
// RV32E-style instance share the core/host control inputs.
module tb_rv32i_reg_file_acc;

    localparam int unsigned XLEN = 32;

    localparam int S_RS1  = 0;
    localparam int S_RS2  = 1;
    localparam int S_RES  = 2;
    localparam int S_RV   = 3;
    localparam int S_BUSY = 4;
    localparam int S_NB1  = 5;
    localparam int S_E1   = 6;

    logic            clk;
    logic            rst;
    logic [4:0]      rs1_addr, rs2_addr, rd_addr;
    logic            rd_we, host_start, result_ack;
    logic [XLEN-1:0] rd_data;
    logic [2*XLEN-1:0] host_args;
    logic [3*XLEN-1:0] host_args_e;

    logic [XLEN-1:0] rs1_data, rs2_data, result;
    logic            host_busy, result_valid;
    logic [XLEN-1:0] nb_rs1, nb_rs2, nb_result;
    logic            nb_busy, nb_valid;
    logic [XLEN-1:0] e_rs1, e_rs2, e_result;
    logic            e_busy, e_valid;

    rv32i_reg_file_acc u_dut (
        .clk(clk), .rst(rst),
        .rs1_addr(rs1_addr), .rs1_data(rs1_data),
        .rs2_addr(rs2_addr), .rs2_data(rs2_data),
        .rd_we(rd_we), .rd_addr(rd_addr), .rd_data(rd_data),
        .host_start(host_start), .host_args(host_args),
        .host_busy(host_busy), .result(result),
        .result_valid(result_valid), .result_ack(result_ack)
    );

    rv32i_reg_file_acc #(.BYPASS(1'b0)) u_nb (
        .clk(clk), .rst(rst),
        .rs1_addr(rs1_addr), .rs1_data(nb_rs1),
        .rs2_addr(rs2_addr), .rs2_data(nb_rs2),
        .rd_we(rd_we), .rd_addr(rd_addr), .rd_data(rd_data),
        .host_start(host_start), .host_args(host_args),
        .host_busy(nb_busy), .result(nb_result),
        .result_valid(nb_valid), .result_ack(result_ack)
    );

    rv32i_reg_file_acc #(.NREGS(16), .NUM_ARGS(3), .ARG_BASE(12), .START_REG(15)) u_e (
        .clk(clk), .rst(rst),
        .rs1_addr(rs1_addr), .rs1_data(e_rs1),
        .rs2_addr(rs2_addr), .rs2_data(e_rs2),
        .rd_we(rd_we), .rd_addr(rd_addr), .rd_data(rd_data),
        .host_start(host_start), .host_args(host_args_e),
        .host_busy(e_busy), .result(e_result),
        .result_valid(e_valid), .result_ack(result_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string           tag;
        int              src;
        logic [XLEN-1:0] exp;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [XLEN-1:0] obs,
                         input logic [XLEN-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [XLEN-1:0] observe(input int src);
        case (src)
            S_RS1:   return rs1_data;
            S_RS2:   return rs2_data;
            S_RES:   return result;
            S_RV:    return XLEN'(result_valid);
            S_BUSY:  return XLEN'(host_busy);
            S_NB1:   return nb_rs1;
            S_E1:    return e_rs1;
            default: return 'x;
        endcase
    endfunction

    task automatic push(input string tag, input int src, input logic [XLEN-1:0] v);
        sbq.push_back('{tag: tag, src: src, exp: v});
    endtask

    // Let combinational outputs settle, then compare every queued expectation.
    task automatic drain();
        exp_t e;
        #1;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            check(e.tag, observe(e.src), e.exp);
        end
    endtask

    task automatic probe(input string tag, input int src, input logic [4:0] a,
                         input logic [XLEN-1:0] v);
        rs1_addr = a;
        push(tag, src, v);
        drain();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [XLEN-1:0] d);
        rd_we = 1'b1; rd_addr = a; rd_data = d;
        step();
        rd_we = 1'b0;
    endtask

    task automatic status(input string tag, input logic [XLEN-1:0] res,
                          input logic rv, input logic busy);
        push({tag, "_result"}, S_RES, res);
        push({tag, "_valid"}, S_RV, XLEN'(rv));
        push({tag, "_busy"}, S_BUSY, XLEN'(busy));
        drain();
    endtask

    initial begin
        rst = 1'b1; rs1_addr = '0; rs2_addr = '0; rd_addr = '0; rd_we = 1'b0;
        rd_data = '0; host_start = 1'b0; result_ack = 1'b0;
        host_args = '0; host_args_e = '0;
        #2;

        // Reset state: every address reads zero, status idle.
        for (int a = 0; a < 32; a++) begin
            probe($sformatf("rst_x%0d", a), S_RS1, 5'(a), '0);
        end
        status("rst", '0, 1'b0, 1'b0);

        @(negedge clk); rst = 1'b0;
        #1;

        write_reg(5'd5, 32'hDEADBEEF);
        probe("x5_wr", S_RS1, 5'd5, 32'hDEADBEEF);
        write_reg(5'd0, 32'hFFFF_FFFF);
        probe("x0_wr", S_RS1, 5'd0, '0);

        // Same-cycle forwarding vs. registered visibility.
        rd_we = 1'b1; rd_addr = 5'd7; rd_data = 32'h1234; rs1_addr = 5'd7;
        push("byp_on", S_RS1, 32'h1234);
        push("byp_off_same", S_NB1, '0);
        drain();
        step();
        rd_we = 1'b0;
        push("byp_off_next", S_NB1, 32'h1234);
        drain();

        // Launch a job.
        host_args   = {32'd18, 32'd48};
        host_args_e = {32'd30, 32'd20, 32'd10};
        host_start  = 1'b1;
        step();
        host_start = 1'b0;
        rs2_addr = 5'd29;
        push("arg1", S_RS2, 32'd18);
        drain();
        probe("arg0", S_RS1, 5'd28, 32'd48);
        probe("start_run", S_RS1, 5'd31, 32'd1);
        status("run", '0, 1'b0, 1'b1);
        probe("e_arg0", S_E1, 5'd12, 32'd10);
        probe("e_arg1", S_E1, 5'd13, 32'd20);
        probe("e_arg2", S_E1, 5'd14, 32'd30);
        probe("e_start", S_E1, 5'd15, 32'd1);

        write_reg(5'd28, 32'd0);
        probe("arg_wr_drop", S_RS1, 5'd28, 32'd48);

        // host_start in RUN must not recapture arguments.
        host_args = {32'd77, 32'd99};
        host_start = 1'b1;
        step();
        host_start = 1'b0;
        probe("run_restart0", S_RS1, 5'd28, 32'd48);
        probe("run_restart1", S_RS1, 5'd29, 32'd18);

        write_reg(5'd10, 32'd6);
        status("done", 32'd6, 1'b1, 1'b1);
        probe("start_done", S_RS1, 5'd31, '0);
        probe("x10_done", S_RS1, 5'd10, 32'd6);

        // Ack together with start in DONE: back to IDLE, no new job.
        host_args = {32'd5, 32'd5};
        host_start = 1'b1; result_ack = 1'b1;
        step();
        host_start = 1'b0; result_ack = 1'b0;
        status("ack", 32'd6, 1'b0, 1'b0);
        probe("ack_arg0", S_RS1, 5'd28, 32'd48);
        step();
        status("no_job", 32'd6, 1'b0, 1'b0);

        // Out-of-range access on the 16-register instance.
        write_reg(5'd20, 32'hABCD);
        probe("e_x20", S_E1, 5'd20, '0);
        probe("x20", S_RS1, 5'd20, 32'hABCD);

        // Result register write outside RUN touches only the GPR.
        write_reg(5'd10, 32'h55);
        status("idle_x10", 32'd6, 1'b0, 1'b0);
        probe("idle_x10_gpr", S_RS1, 5'd10, 32'h55);

        // Reset in the middle of a job.
        host_args = {32'd9, 32'd7};
        host_start = 1'b1;
        step();
        host_start = 1'b0;
        probe("job2_arg0", S_RS1, 5'd28, 32'd7);
        rst = 1'b1;
        probe("mid_rst_arg0", S_RS1, 5'd28, '0);
        probe("mid_rst_arg1", S_RS1, 5'd29, '0);
        probe("mid_rst_x5", S_RS1, 5'd5, '0);
        probe("mid_rst_start", S_RS1, 5'd31, '0);
        status("mid_rst", '0, 1'b0, 1'b0);
        @(negedge clk); rst = 1'b0;
        #1;

        host_args = {32'd4, 32'd3};
        host_start = 1'b1;
        step();
        host_start = 1'b0;
        probe("job3_arg1", S_RS1, 5'd29, 32'd4);
        write_reg(5'd10, 32'h77);
        status("job3_done", 32'h77, 1'b1, 1'b1);
        result_ack = 1'b1;
        step();
        result_ack = 1'b0;
        status("job3_ack", 32'h77, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
